// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with transmit FIFO; optional parity via UART_TX_PARITY_EN
module uart_tx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                            uart_clock,
    input  logic                            uart_reset,
    input  logic                            tx_valid,
    input  logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            tx_ready,
    input  logic [DIV_WIDTH-1:0]            baud_div,
    input  logic                            two_stop,
`ifdef UART_TX_PARITY_EN
    input  logic                            parity_en,
    input  logic                            parity_odd,
`endif
    output logic                            uart_d_out,
    output logic                            uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] head;

    logic [2:0]            state;
    logic [DIV_WIDTH-1:0]  clk_cnt;
    logic [DIV_WIDTH-1:0]  lat_div;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  lat_two;
`ifdef UART_TX_PARITY_EN
    logic                  lat_par_en;
    logic                  par_bit;
`endif

    logic push;
    logic pop;
    logic queued;
    logic tick;
    logic stop_last;

    assign tx_ready     = (fifo_level != FULL_LVL);
    assign push         = tx_valid && tx_ready;
    assign queued       = (fifo_level != '0);
    assign head         = mem[rd_ptr];
    assign tick         = (clk_cnt == lat_div);
    assign stop_last    = (bit_cnt == (lat_two ? 4'd1 : 4'd0));
    // A new frame starts from IDLE, or directly off the last stop bit so there is no idle gap.
    assign pop          = queued && ((state == S_IDLE) ||
                                     ((state == S_STOP) && tick && stop_last));
    assign uart_tx_busy = (state != S_IDLE) || queued;

    always_ff @(posedge uart_clock) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            state      <= S_IDLE;
            clk_cnt    <= '0;
            lat_div    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            lat_two    <= 1'b0;
            uart_d_out <= 1'b1;
`ifdef UART_TX_PARITY_EN
            lat_par_en <= 1'b0;
            par_bit    <= 1'b0;
`endif
        end else if (pop) begin
            state      <= S_START;
            clk_cnt    <= '0;
            lat_div    <= baud_div;
            bit_cnt    <= '0;
            shreg      <= head;
            lat_two    <= two_stop;
            uart_d_out <= 1'b0;
`ifdef UART_TX_PARITY_EN
            lat_par_en <= parity_en;
            par_bit    <= (^head) ^ parity_odd;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    uart_d_out <= 1'b1;
                end
                S_START: begin
                    if (tick) begin
                        clk_cnt    <= '0;
                        state      <= S_DATA;
                        uart_d_out <= shreg[0];
                        shreg      <= shreg >> 1;
                    end else begin
                        clk_cnt <= clk_cnt + DIV_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        clk_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            if (lat_par_en) begin
                                state      <= S_PARITY;
                                uart_d_out <= par_bit;
                            end else begin
                                state      <= S_STOP;
                                uart_d_out <= 1'b1;
                            end
`else
                            state      <= S_STOP;
                            uart_d_out <= 1'b1;
`endif
                        end else begin
                            bit_cnt    <= bit_cnt + 4'd1;
                            uart_d_out <= shreg[0];
                            shreg      <= shreg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + DIV_WIDTH'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        clk_cnt    <= '0;
                        bit_cnt    <= '0;
                        state      <= S_STOP;
                        uart_d_out <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + DIV_WIDTH'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        clk_cnt <= '0;
                        if (stop_last) begin
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    uart_d_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param (parity cases under UART_TX_PARITY_EN)
module tb_uart_tx_param;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIVW  = 16;

    logic            uart_clock = 1'b0;
    logic            uart_reset = 1'b0;
    logic            tx_valid   = 1'b0;
    logic [DW-1:0]   tx_data    = '0;
    logic [DIVW-1:0] baud_div   = '0;
    logic            two_stop   = 1'b0;
    logic            parity_en  = 1'b0;
    logic            parity_odd = 1'b0;
    logic            tx_ready;
    logic            uart_d_out;
    logic            uart_tx_busy;
    logic [2:0]      fifo_level;

    always #5 uart_clock = ~uart_clock;

    uart_tx_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
        .uart_clock   (uart_clock),
        .uart_reset   (uart_reset),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .baud_div     (baud_div),
        .two_stop     (two_stop),
`ifdef UART_TX_PARITY_EN
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
`endif
        .uart_d_out   (uart_d_out),
        .uart_tx_busy (uart_tx_busy),
        .fifo_level   (fifo_level)
    );

    typedef struct {
        logic [7:0] data;
        int         div;
        logic       two;
        logic       pen;
        logic       podd;
        logic       b2b;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        int         div;
        logic       two;
        logic       pen;
        logic       podd;
        int         frame_clks;
    } vec_t;

    frame_t sb_q[$];
    vec_t   vecs[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    logic   mon_abort = 1'b0;
    logic   mon_busy  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Line monitor: rebuilds each expected frame from the scoreboard and checks every clock of it.
    initial begin : monitor
        frame_t     f;
        logic [15:0] bits;
        int         nb;
        int         idle;
        bit         ok;
        bit         ab;
        forever begin
            idle = 0;
            @(negedge uart_clock);
            while (mon_abort || uart_d_out !== 1'b0) begin
                idle++;
                @(negedge uart_clock);
            end
            mon_busy = 1'b1;
            check("frame_expected", int'(sb_q.size() > 0), 1);
            if (sb_q.size() == 0) begin
                while (uart_d_out === 1'b0) @(negedge uart_clock);
                mon_busy = 1'b0;
                continue;
            end
            f = sb_q.pop_front();
            if (f.b2b) check($sformatf("no_idle_gap_%02h", f.data), idle, 0);
            bits = '0;
            nb = 0;
            bits[nb] = 1'b0; nb++;
            for (int i = 0; i < DW; i++) begin
                bits[nb] = f.data[i]; nb++;
            end
            if (f.pen) begin
                bits[nb] = (^f.data) ^ f.podd; nb++;
            end
            bits[nb] = 1'b1; nb++;
            if (f.two) begin
                bits[nb] = 1'b1; nb++;
            end
            ab = 1'b0;
            for (int b = 0; b < nb && !ab; b++) begin
                ok = 1'b1;
                for (int k = 0; k <= f.div; k++) begin
                    if (!(b == 0 && k == 0)) @(negedge uart_clock);
                    if (mon_abort) begin
                        ab = 1'b1;
                        break;
                    end
                    if (uart_d_out !== bits[b]) ok = 1'b0;
                end
                if (!ab) check($sformatf("frame_%02h_bit%0d", f.data, b), int'(ok), 1);
            end
            mon_busy = 1'b0;
        end
    end

    task automatic wait_drain(input int maxc);
        int c = 0;
        while ((sb_q.size() != 0 || mon_busy || uart_tx_busy) && c < maxc) begin
            @(negedge uart_clock);
            c++;
        end
        check("drain_in_time", int'(c < maxc), 1);
        repeat (2) @(negedge uart_clock);
    endtask

    task automatic push_word(input logic [7:0] d, input int div, input logic b2b);
        @(negedge uart_clock);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge uart_clock);
        sb_q.push_back('{d, div, two_stop, parity_en, parity_odd, b2b});
        #1 tx_valid = 1'b0;
    endtask

    task automatic send_single(input vec_t v);
        @(negedge uart_clock);
        baud_div   = DIVW'(v.div);
        two_stop   = v.two;
        parity_en  = v.pen;
        parity_odd = v.podd;
        push_word(v.data, v.div, 1'b0);
        @(negedge uart_clock);
        check("line_high_at_push", int'(uart_d_out), 1);
        check("level_after_push", int'(fifo_level), 1);
        for (int k = 1; k <= v.frame_clks + 1; k++) begin
            @(negedge uart_clock);
            if (k == 1) check($sformatf("start_latency_%02h", v.data), int'(uart_d_out), 0);
            if (k == v.frame_clks) check($sformatf("busy_last_clk_%02h", v.data), int'(uart_tx_busy), 1);
            if (k == v.frame_clks + 1) begin
                check($sformatf("busy_fall_%02h", v.data), int'(uart_tx_busy), 0);
                check("line_idle_after", int'(uart_d_out), 1);
            end
        end
        wait_drain(200);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   acc;
        logic r;
        int   hi_bad;

        vecs.push_back('{8'hA5, 3, 1'b0, 1'b0, 1'b0, 40});
        vecs.push_back('{8'hA5, 3, 1'b1, 1'b0, 1'b0, 44});
        vecs.push_back('{8'h3C, 0, 1'b0, 1'b0, 1'b0, 10});
        vecs.push_back('{8'hFF, 1, 1'b1, 1'b0, 1'b0, 22});
        vecs.push_back('{8'h00, 2, 1'b0, 1'b0, 1'b0, 30});
        vecs.push_back('{8'h81, 0, 1'b1, 1'b0, 1'b0, 11});
`ifdef UART_TX_PARITY_EN
        vecs.push_back('{8'hA5, 3, 1'b0, 1'b1, 1'b0, 44});
        vecs.push_back('{8'hA5, 3, 1'b0, 1'b1, 1'b1, 44});
`endif

        repeat (3) @(negedge uart_clock);
        check("rst_line", int'(uart_d_out), 1);
        check("rst_ready", int'(tx_ready), 1);
        check("rst_busy", int'(uart_tx_busy), 0);
        check("rst_level", int'(fifo_level), 0);
        uart_reset = 1'b1;
        repeat (2) @(negedge uart_clock);
        check("post_rst_line", int'(uart_d_out), 1);

        foreach (vecs[i]) send_single(vecs[i]);
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // FIFO fill with tx_valid held: one word is taken straight into the shifter.
        @(negedge uart_clock);
        baud_div = 16'd9;
        two_stop = 1'b0;
        acc      = 0;
        tx_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge uart_clock);
            tx_data = DW'(acc + 1);
            r = tx_ready;
            @(posedge uart_clock);
            if (r) begin
                sb_q.push_back('{8'(acc + 1), 9, 1'b0, 1'b0, 1'b0, (acc > 0)});
                acc++;
            end
        end
        @(negedge uart_clock);
        tx_valid = 1'b0;
        check("fifo_accepted", acc, 5);
        check("fifo_full_level", int'(fifo_level), 4);
        check("fifo_full_ready", int'(tx_ready), 0);
        wait_drain(2000);

        // Divisor change mid-frame only affects the following frame.
        @(negedge uart_clock);
        baud_div = 16'd0;
        push_word(8'h5A, 0, 1'b0);
        baud_div = 16'd0;
        push_word(8'hC3, 7, 1'b1);
        repeat (3) @(negedge uart_clock);
        baud_div = 16'd7;
        wait_drain(500);

        // Reset mid-DATA with two words queued.
        @(negedge uart_clock);
        baud_div = 16'd9;
        push_word(8'hB1, 9, 1'b0);
        push_word(8'hB2, 9, 1'b1);
        push_word(8'hB3, 9, 1'b1);
        repeat (20) @(posedge uart_clock);
        #1 check("pre_rst_level", int'(fifo_level), 2);
        @(posedge uart_clock);
        mon_abort = 1'b1;
        #2 uart_reset = 1'b0;
        #1;
        check("midrst_line", int'(uart_d_out), 1);
        check("midrst_level", int'(fifo_level), 0);
        check("midrst_ready", int'(tx_ready), 1);
        check("midrst_busy", int'(uart_tx_busy), 0);
        sb_q.delete();
        repeat (3) @(negedge uart_clock);
        uart_reset = 1'b1;
        @(negedge uart_clock);
        mon_abort = 1'b0;
        hi_bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge uart_clock);
            if (uart_d_out !== 1'b1 || uart_tx_busy !== 1'b0) hi_bad++;
        end
        check("quiet_after_reset", hi_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
